ru_rr_arb_2to1: RTL and testbench
=================================

RU_RR_ARB_2TO1 -- requirements
Module: ru_rr_arb_2to1

Interface
REQ-001 SHALL have parameter RU_FIFO_WIDTH, default 32, the data beat width.
REQ-002 SHALL have parameter MAX_BURST, default 4 (legal 1..255), the maximum beats per grant before forced rotation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 2, per-requester beat valid (one per RU FIFO output).
REQ-006 SHALL have port in_data, input, 2*RU_FIFO_WIDTH, requester i data at bits [(i+1)*W-1 : i*W].
REQ-007 SHALL have port in_last, input, 2, per-requester end-of-packet flag.
REQ-008 SHALL have port in_ready, output, 2, per-requester accept.
REQ-009 SHALL have port out_valid, output, 1, merged output beat valid.
REQ-010 SHALL have port out_data, output, RU_FIFO_WIDTH, merged output data.
REQ-011 SHALL have port out_last, output, 1, end-of-packet flag travelling with out_data.
REQ-012 SHALL have port out_src, output, 1, index of the requester that produced the current output beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 SHALL transfer a beat on any interface only in a cycle where valid and ready are both 1.
REQ-015 SHALL hold one output register (out_valid/out_data/out_last/out_src); load_ok = ~out_valid | out_ready.
REQ-016 SHALL keep out_data/out_last/out_src stable while out_valid=1 and out_ready=0.
REQ-017 SHALL implement FSM states IDLE and LOCK, plus registers owner (1 bit), rr_ptr (1 bit), beat_cnt (8 bits).
REQ-018 SHALL, in IDLE, select requester sel = rr_ptr if in_valid[rr_ptr], else ~rr_ptr if in_valid[~rr_ptr]; no valid means no selection.
REQ-019 SHALL drive in_ready[sel]=load_ok in IDLE (same-cycle grant) and in_ready of the other requester 0.
REQ-020 SHALL, in LOCK, drive in_ready[owner]=load_ok and in_ready[~owner]=0, regardless of the other requester's in_valid.
REQ-021 SHALL, on an accepted beat, load it into the output register next edge with out_src = accepting index; input-to-output latency is exactly 1 cycle.
REQ-022 SHALL, on the first accepted beat in IDLE, set owner=sel, beat_cnt=1, go LOCK unless in_last=1 or MAX_BURST=1.
REQ-023 SHALL, in LOCK, increment beat_cnt per accepted beat.
REQ-024 SHALL release (go IDLE, rr_ptr = ~owner) on the edge after accepting a beat with in_last=1 or with beat_cnt reaching MAX_BURST, whichever first.
REQ-025 SHALL apply the same release rule (rr_ptr = ~sel) for a single-beat grant taken directly from IDLE.
REQ-026 SHALL stay in LOCK while the owner's in_valid=0 (no timeout); the other requester stalls.
REQ-027 SHALL, when out_ready=0 and out_valid=1, hold all in_ready at 0 and all state unchanged.
REQ-028 SHALL sustain one beat per cycle when out_ready is held 1.
REQ-029 SHALL leave rr_ptr unchanged on cycles with no accepted beat.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, out_valid=0, out_last=0, out_src=0, out_data=0.
REQ-031 SHALL drive in_ready=0 during reset; reset asserted mid-packet discards the registered beat and lock with no flush.
REQ-032 SHALL accept a beat in the first cycle after rst_n deasserts if a requester is valid.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, LOCK) and the MAX_BURST counter width constant (8) in the shared RU package.
REQ-034 SHALL be a single module with no sub-modules; the round-robin select is inline logic.

Verification
REQ-035 Reset: rst_n=0 with in_valid=2'b11 -> in_ready=0, out_valid=0; first cycle after release, requester 0 granted (rr_ptr=0).
REQ-036 Round-robin: both valid, in_last=1 every beat, out_ready=1 -> out_src sequence 0,1,0,1, one beat per cycle.
REQ-037 Burst cap: MAX_BURST=4, requester 0 sends 10-beat packet, requester 1 valid -> out_src 0,0,0,0,1..., requester 0 resumes after 1's grant.
REQ-038 Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data frozen, in_ready=0, no beat lost or duplicated; sequence intact after release.
REQ-039 Lock hold: owner drops in_valid for 3 cycles mid-packet while requester 1 valid -> in_ready[1]=0 throughout; owner's packet completes first.
REQ-040 Reset mid-packet: rst_n pulsed during a locked 6-beat packet -> out_valid=0 immediately, state IDLE, rr_ptr=0 after release.

Source files
------------

// File: rtl/ru_rr_arb_2to1_pkg.sv
// Shared RU definitions for the 2:1 round-robin packet arbiter.
package ru_rr_arb_2to1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/ru_rr_arb_2to1.sv
// 2:1 round-robin packet arbiter merging two RU FIFO streams into one registered output.
// Handshake: a beat moves on an interface only in a cycle where its valid and ready are both 1.
module ru_rr_arb_2to1
  import ru_rr_arb_2to1_pkg::*;
#(
  parameter int RU_FIFO_WIDTH = 32,
  parameter int MAX_BURST     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 in_valid,
  input  logic [2*RU_FIFO_WIDTH-1:0] in_data,
  input  logic [1:0]                 in_last,
  output logic [1:0]                 in_ready,
  output logic                       out_valid,
  output logic [RU_FIFO_WIDTH-1:0]   out_data,
  output logic                       out_last,
  output logic                       out_src,
  input  logic                       out_ready,
  output arb_state_e                 dbg_state
);

  localparam logic [BEAT_CNT_W-1:0] MAX_BURST_C = BEAT_CNT_W'(MAX_BURST);

  arb_state_e               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [RU_FIFO_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     out_src_q, out_src_d;

  logic                     load_ok;
  logic                     sel;
  logic                     sel_vld;
  logic                     grant_idx;
  logic                     grant_en;
  logic                     accept;
  logic [RU_FIFO_WIDTH-1:0] beat_data;
  logic                     beat_last;
  logic [BEAT_CNT_W-1:0]    cnt_inc;
  logic                     release_grant;

  always_comb begin
    load_ok = ~out_valid_q | out_ready;

    // Prefer the requester rr_ptr points at; fall back to the other one.
    sel     = rr_ptr_q;
    sel_vld = 1'b0;
    if (in_valid[rr_ptr_q]) begin
      sel     = rr_ptr_q;
      sel_vld = 1'b1;
    end else if (in_valid[~rr_ptr_q]) begin
      sel     = ~rr_ptr_q;
      sel_vld = 1'b1;
    end

    grant_idx = (state_q == ST_LOCK) ? owner_q : sel;
    grant_en  = (state_q == ST_LOCK) | sel_vld;

    in_ready = 2'b00;
    if (rst_n && grant_en && load_ok) begin
      in_ready[grant_idx] = 1'b1;
    end

    accept    = |(in_ready & in_valid);
    beat_data = grant_idx ? in_data[2*RU_FIFO_WIDTH-1:RU_FIFO_WIDTH]
                          : in_data[RU_FIFO_WIDTH-1:0];
    beat_last = in_last[grant_idx];

    cnt_inc       = (state_q == ST_IDLE) ? BEAT_CNT_W'(1) : beat_cnt_q + BEAT_CNT_W'(1);
    release_grant = beat_last | (cnt_inc == MAX_BURST_C);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    if (load_ok) begin
      out_valid_d = accept;
    end

    if (accept) begin
      out_data_d = beat_data;
      out_last_d = beat_last;
      out_src_d  = grant_idx;
      owner_d    = grant_idx;
      beat_cnt_d = cnt_inc;
      // Release hands priority to the other requester for the next grant.
      if (release_grant) begin
        state_d  = ST_IDLE;
        rr_ptr_d = ~grant_idx;
      end else begin
        state_d  = ST_LOCK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ru_rr_arb_2to1.sv
// Randomized bench for ru_rr_arb_2to1 against a transaction-level arbitration model.
module tb_ru_rr_arb_2to1;
  import ru_rr_arb_2to1_pkg::*;

  localparam int W  = 32;
  localparam int MB = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic [1:0]     in_valid;
  logic [2*W-1:0] in_data;
  logic [1:0]     in_last;
  logic [1:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_src;
  logic           out_ready;
  arb_state_e     dbg_state;

  ru_rr_arb_2to1 #(.RU_FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus sources ----------------
  beat_t q0[$];
  beat_t q1[$];
  int    seq0 = 0;
  int    seq1 = 0;
  int    pkt_min, pkt_max, p_valid, p_ready;

  task automatic refill(input int src);
    int len;
    beat_t b;
    len = int'($urandom_range(pkt_max, pkt_min));
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      if (src == 0) begin
        b.data = {8'hA0, 24'(seq0)};
        seq0++;
        q0.push_back(b);
      end else begin
        b.data = {8'hB1, 24'(seq1)};
        seq1++;
        q1.push_back(b);
      end
    end
  endtask

  task automatic drive_inputs(input logic force_valid);
    if (q0.size() == 0) refill(0);
    if (q1.size() == 0) refill(1);
    in_data  = {q1[0].data, q0[0].data};
    in_last  = {q1[0].last, q0[0].last};
    in_valid[0] = force_valid || ($urandom_range(99, 0) < p_valid);
    in_valid[1] = force_valid || ($urandom_range(99, 0) < p_valid);
    out_ready   = force_valid || ($urandom_range(99, 0) < p_ready);
  endtask

  // ---------------- reference model ----------------
  // holder: requester owning an open grant (-1 = none); beats: beats taken in that grant;
  // pref: requester favoured when no grant is open.
  int           holder, beats, pref;
  logic         exp_ov;
  logic [W-1:0] exp_od;
  logic         exp_ol, exp_os;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    holder = -1;
    beats  = 0;
    pref   = 0;
    exp_ov = 1'b0;
    exp_od = '0;
    exp_ol = 1'b0;
    exp_os = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: inputs already driven; check grant, advance model, check output register.
  task automatic step_body();
    int    grant;
    logic  stall, acc;
    logic [1:0] exp_rdy;
    beat_t b;
    #1;
    if (exp_ov && out_ready) begin
      if (exp_q.size() == 0) check_eq("deliver_underflow", 64'd1, 64'd0);
      else check_eq("deliver_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
    stall = exp_ov && !out_ready;
    grant = -1;
    if (!stall) begin
      if (holder >= 0) grant = holder;
      else if (in_valid[pref]) grant = pref;
      else if (in_valid[1-pref]) grant = 1 - pref;
    end
    exp_rdy = 2'b00;
    if (grant >= 0) exp_rdy[grant] = 1'b1;
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = (grant >= 0) && in_valid[grant];
    if (acc) begin
      b = (grant == 0) ? q0.pop_front() : q1.pop_front();
      exp_q.push_back(b.data);
      exp_od = b.data;
      exp_ol = b.last;
      exp_os = grant[0];
      beats  = (holder < 0) ? 1 : beats + 1;
      holder = grant;
      if (b.last || beats == MB) begin
        holder = -1;
        pref   = 1 - grant;
      end
    end
    if (!stall) exp_ov = acc;
    @(posedge clk);
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check_eq("out_data", 64'(out_data), 64'(exp_od));
      check_eq("out_last", 64'(out_last), 64'(exp_ol));
      check_eq("out_src", 64'(out_src), 64'(exp_os));
    end
    check_eq("state", 64'(dbg_state), (holder >= 0) ? 64'(ST_LOCK) : 64'(ST_IDLE));
  endtask

  task automatic step();
    @(negedge clk);
    drive_inputs(1'b0);
    step_body();
  endtask

  // Reset with both requesters valid; released on a negedge so the next edge is the first live one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_inputs(1'b1);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready_hold", 64'(in_ready), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    model_reset();
    rst_n = 1'b1;
    drive_inputs(1'b1);
    step_body();
  endtask

  task automatic set_phase(input int mn, input int mx, input int pv, input int pr);
    pkt_min = mn;
    pkt_max = mx;
    p_valid = pv;
    p_ready = pr;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 2'b00;
    in_data   = '0;
    in_last   = 2'b00;
    out_ready = 1'b0;
    model_reset();

    // single-beat packets, full throughput: strict alternation
    set_phase(1, 1, 100, 100);
    do_reset();
    repeat (20) step();

    // long packets: burst cap forces rotation every MB beats
    set_phase(10, 10, 100, 100);
    repeat (40) step();

    // downstream backpressure
    set_phase(1, 8, 100, 40);
    repeat (100) step();

    // requester valid gaps, including the owner mid-packet
    set_phase(1, 8, 55, 100);
    repeat (100) step();

    // reset in the middle of a locked packet
    q0.delete();
    q1.delete();
    set_phase(6, 6, 100, 100);
    repeat (3) step();
    do_reset();
    repeat (30) step();

    // mixed traffic
    set_phase(1, 12, 70, 70);
    repeat (400) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
